msg_block_buf: RTL and testbench
================================

MSG_BLOCK_BUF -- requirements
Module: msg_block_buf

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  clock.
- nreset  in  1  reset; synchronous, active-low.
- data_v_i  in  1  byte valid from host interface.
- data_i  in  8  message byte.
- data_idx_i  in  6  byte index within the 64-byte block.
- block_first_i  in  1  current block is the first of the message.
- block_last_i  in  1  current block is the last of the message.
- kk_i  in  6  key length, bytes.
- ll_i  in  64  message length, bytes.
- ready_v_o  out  1  buffer can accept bytes.
- blk_v_o  out  1  complete block offered to the compression core.
- blk_o  out  512  block; byte k at bits [8k+7:8k], little-endian 32-bit words.
- t_o  out  64  byte offset counter for this block.
- first_o  out  1  offered block is the first.
- last_o  out  1  offered block is the last (finalisation flag).
- core_ready_i  in  1  core accepts the block when high with blk_v_o.
- err_o  out  1  sticky overrun error.

Function
REQ-002 SHALL implement states FILL and FULL; reset state FILL.
REQ-003 In FILL, a byte with data_v_i=1 SHALL be written to blk byte data_idx_i; other bytes unchanged.
REQ-004 Last-block length SHALL be computed as L = ll_i mod 64, with L=0 mapped to 64.
REQ-005 A block SHALL complete on a byte with data_idx_i=63, or with block_last_i=1 and data_idx_i=L-1.
REQ-006 On completion, the state SHALL be FULL and blk_v_o=1 in the next cycle; latency is 1 cycle from the final byte.
REQ-007 first_o and last_o SHALL capture block_first_i and block_last_i at the completing byte.
REQ-008 t SHALL be a 64-bit register, cleared when a byte with block_first_i=1 and data_idx_i=0 is written.
REQ-009 t_o for a non-last block SHALL equal the previous block's t_o plus 64, or 64 if the block is first.
REQ-010 t_o for the last block SHALL equal ll_i plus 64 when kk_i!=0, and ll_i when kk_i=0.
REQ-011 All additions SHALL be modulo 2^64.
REQ-012 blk_o, t_o, first_o and last_o SHALL be held stable while blk_v_o=1.
REQ-013 blk_v_o SHALL remain 1 until core_ready_i=1; there is no retraction.
REQ-014 On accept (blk_v_o & core_ready_i), blk_o SHALL be zeroed and the state SHALL return to FILL in the next cycle.
- Zeroing provides padding for partial last blocks.
REQ-015 ready_v_o SHALL equal 1 in FILL and 0 in FULL; it is a registered state decode.
REQ-016 A byte with data_v_i=1 while in FULL, including the accept cycle, SHALL be dropped and SHALL set err_o.
REQ-017 err_o SHALL clear only on reset.
REQ-018 Bytes with block_last_i=1 and data_idx_i >= L SHALL be ignored and SHALL NOT complete the block.
REQ-019 A message with ll_i=0 and kk_i=0 is outside the supported range; no behaviour is defined for it.

Reset
REQ-020 On nreset=0 at a clk edge: state FILL, blk_o=0, t=0, blk_v_o=0, first_o=0, last_o=0, err_o=0, ready_v_o=1.
REQ-021 Reset SHALL apply mid-fill and while FULL; any pending block is discarded without handshake.

Verification
REQ-022 Single full block: kk=0, ll=64; bytes 0..63 with first=last=1, values k -> blk_v_o one cycle after idx 63; blk_o byte k = k; t_o=64; first_o=1; last_o=1.
REQ-023 Partial last block: kk=0, ll=70; block 0 with 64 bytes, then block 1 with last=1 and 6 bytes 0xAA -> block 0 t_o=64, last_o=0; block 1 t_o=70, bytes 0..5 = 0xAA, bytes 6..63 = 0.
REQ-024 Keyed message: kk=16, ll=3; key block of 64 bytes (first=1), then 3-byte last block -> t_o=64 then t_o=67; last_o=1 on the second block only.
REQ-025 Backpressure: hold core_ready_i=0 for 10 cycles after completion -> blk_v_o and outputs stable, ready_v_o=0; a byte sent in that window -> err_o=1 and blk_o unchanged.
REQ-026 Reset during fill at idx 30 -> next cycle blk_o=0 and ready_v_o=1; refill of a full block yields a correct block with t_o=64.

Source files
------------

// File: rtl/msg_block_buf.sv
// Message block buffer: collects host bytes into a 64-byte block and offers it
// to the compression core with byte offset counter and first/last flags.

module msg_block_lane (
  input  logic       clk,
  input  logic       nreset,
  input  logic       we,
  input  logic       clr,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (!nreset)  q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module msg_block_buf (
  input  logic         clk,
  input  logic         nreset,
  input  logic         data_v_i,
  input  logic [7:0]   data_i,
  input  logic [5:0]   data_idx_i,
  input  logic         block_first_i,
  input  logic         block_last_i,
  input  logic [5:0]   kk_i,
  input  logic [63:0]  ll_i,
  output logic         ready_v_o,
  output logic         blk_v_o,
  output logic [511:0] blk_o,
  output logic [63:0]  t_o,
  output logic         first_o,
  output logic         last_o,
  input  logic         core_ready_i,
  output logic         err_o
);
  localparam int NUM_BYTES = 64;

  typedef enum logic {FILL, FULL} state_t;

  state_t state_q, state_d;
  logic [NUM_BYTES-1:0][7:0] blk_q;
  logic [63:0] t_q;
  logic        ready_q, blk_v_q, first_q, last_q, err_q;

  // ll mod 64; zero means the last block is a full 64 bytes
  logic [5:0] l_mod;
  logic       ign, wr, done, accept, clr_t;

  assign l_mod  = ll_i[5:0];
  assign ign    = block_last_i && (l_mod != 6'd0) && (data_idx_i >= l_mod);
  assign wr     = data_v_i && (state_q == FILL) && !ign;
  assign done   = wr && ((data_idx_i == 6'd63) ||
                         (block_last_i && (data_idx_i == l_mod - 6'd1)));
  assign accept = (state_q == FULL) && core_ready_i;
  assign clr_t  = wr && block_first_i && (data_idx_i == 6'd0);

  always_ff @(posedge clk) begin
    if (!nreset) state_q <= FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (done)         state_d = FULL;
      FULL:    if (core_ready_i) state_d = FILL;
      default:                   state_d = FILL;
    endcase
  end

  // handshake outputs are flopped decodes of the next state
  always_ff @(posedge clk) begin
    if (!nreset) begin
      ready_q <= 1'b1;
      blk_v_q <= 1'b0;
    end else begin
      ready_q <= (state_d == FILL);
      blk_v_q <= (state_d == FULL);
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_BYTES; k++) begin : g_lane
      msg_block_lane u_lane (
        .clk    (clk),
        .nreset (nreset),
        .we     (wr && (data_idx_i == 6'(k))),
        .clr    (accept),
        .d      (data_i),
        .q      (blk_q[k])
      );
    end
  endgenerate

  // last block reports total length (plus key block); others step by 64
  always_ff @(posedge clk) begin
    if (!nreset) begin
      t_q <= '0;
    end else if (done) begin
      if (block_last_i) t_q <= ll_i + ((kk_i != 6'd0) ? 64'd64 : 64'd0);
      else              t_q <= (clr_t ? 64'd0 : t_q) + 64'd64;
    end else if (clr_t) begin
      t_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (done) begin
        first_q <= block_first_i;
        last_q  <= block_last_i;
      end
      if (data_v_i && (state_q == FULL)) err_q <= 1'b1;
    end
  end

  assign ready_v_o = ready_q;
  assign blk_v_o   = blk_v_q;
  assign blk_o     = blk_q;
  assign t_o       = t_q;
  assign first_o   = first_q;
  assign last_o    = last_q;
  assign err_o     = err_q;
endmodule

// File: tb/tb_msg_block_buf.sv
// Randomized bench for msg_block_buf against a message-level reference model.

module tb_msg_block_buf;
  logic         clk = 1'b0;
  logic         nreset;
  logic         data_v_i;
  logic [7:0]   data_i;
  logic [5:0]   data_idx_i;
  logic         block_first_i, block_last_i;
  logic [5:0]   kk_i;
  logic [63:0]  ll_i;
  logic         ready_v_o, blk_v_o, first_o, last_o, err_o;
  logic [511:0] blk_o;
  logic [63:0]  t_o;
  logic         core_ready_i;

  always #5 clk = ~clk;

  msg_block_buf dut (
    .clk(clk), .nreset(nreset), .data_v_i(data_v_i), .data_i(data_i),
    .data_idx_i(data_idx_i), .block_first_i(block_first_i),
    .block_last_i(block_last_i), .kk_i(kk_i), .ll_i(ll_i),
    .ready_v_o(ready_v_o), .blk_v_o(blk_v_o), .blk_o(blk_o), .t_o(t_o),
    .first_o(first_o), .last_o(last_o), .core_ready_i(core_ready_i),
    .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_cr = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // reference model: message-level view of the offered block
  bit          m_full, m_f, m_l, m_err;
  logic [7:0]  m_b[64];
  logic [63:0] m_t;
  longint unsigned m_cnt;  // blocks completed since the message's first byte

  function automatic logic [511:0] m_pack();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = m_b[i];
    return r;
  endfunction

  task automatic model_edge();
    int L;
    int idx;
    if (!nreset) begin
      m_full = 0; m_f = 0; m_l = 0; m_err = 0; m_t = '0; m_cnt = 0;
      for (int i = 0; i < 64; i++) m_b[i] = 8'h00;
      return;
    end
    if (m_full) begin
      if (data_v_i) m_err = 1;
      if (core_ready_i) begin
        m_full = 0;
        for (int i = 0; i < 64; i++) m_b[i] = 8'h00;
      end
      return;
    end
    if (!data_v_i) return;
    L = int'(ll_i % 64);
    if (L == 0) L = 64;
    idx = int'(data_idx_i);
    if (block_last_i && idx >= L) return;
    m_b[idx] = data_i;
    if (block_first_i && idx == 0) m_cnt = 0;
    if (idx == 63 || (block_last_i && idx == L - 1)) begin
      m_full = 1;
      m_f = block_first_i;
      m_l = block_last_i;
      if (block_last_i) m_t = ll_i + ((kk_i != 0) ? 64'd64 : 64'd0);
      else              m_t = 64'(64 * (m_cnt + 1));
      m_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("ready_v_o", 512'(ready_v_o), 512'(!m_full));
    chk("blk_v_o",   512'(blk_v_o),   512'(m_full));
    chk("err_o",     512'(err_o),     512'(m_err));
    chk("blk_o",     blk_o,           m_pack());
    chk("first_o",   512'(first_o),   512'(m_f));
    chk("last_o",    512'(last_o),    512'(m_l));
    if (m_full) chk("t_o", 512'(t_o), 512'(m_t));
    if (rand_cr) core_ready_i = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!ready_v_o && w < 200) begin step(); w++; end
    if (w >= 200) chk("ready_timeout", 512'(ready_v_o), 512'(1));
  endtask

  task automatic send_byte(input int idx, input logic [7:0] d, input bit f, input bit l);
    wait_ready();
    data_v_i = 1; data_i = d; data_idx_i = 6'(idx);
    block_first_i = f; block_last_i = l;
    step();
    data_v_i = 0;
  endtask

  // mode 0: byte k = k, 1: 0xAA, 2: random; gaps adds random idle cycles
  task automatic send_block(input int n, input bit f, input bit l, input int mode, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step();
      send_byte(i, (mode == 0) ? 8'(i) : (mode == 1) ? 8'hAA : 8'($urandom), f, l);
    end
  endtask

  task automatic do_reset();
    nreset = 0; step(); step(); nreset = 1;
  endtask

  task automatic drain();
    bit save = rand_cr;
    rand_cr = 0; core_ready_i = 1;
    wait_ready();
    rand_cr = save;
  endtask

  task automatic rand_msg();
    int nb, L;
    kk_i = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(1, 63)) : 6'd0;
    if ($urandom_range(0, 3) == 0) ll_i = 64'(64 * $urandom_range(1, 4));
    else                           ll_i = 64'($urandom_range(1, 300));
    nb = int'((ll_i + 63) / 64);
    L = int'(ll_i % 64); if (L == 0) L = 64;
    if (kk_i != 0) send_block(64, 1, 0, 2, 1);
    for (int b = 0; b < nb; b++) begin
      bit lst = (b == nb - 1);
      bit fst = (kk_i == 0) && (b == 0);
      int n = lst ? L : 64;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) step();
        // out-of-range last-block byte slipped in before the final byte
        if (lst && L < 64 && i == n - 1 && $urandom_range(0, 1) == 0)
          send_byte($urandom_range(L, 63), 8'($urandom), fst, 1);
        send_byte(i, 8'($urandom), fst, lst);
      end
    end
  endtask

  initial begin
    nreset = 0; data_v_i = 0; data_i = 0; data_idx_i = 0;
    block_first_i = 0; block_last_i = 0; kk_i = 0; ll_i = 0; core_ready_i = 1;
    do_reset();

    // single full block
    kk_i = 0; ll_i = 64;
    send_block(64, 1, 1, 0, 0);
    drain();

    // partial last block
    ll_i = 70;
    send_block(64, 1, 0, 2, 0);
    send_block(6, 0, 1, 1, 0);
    drain();

    // keyed message
    kk_i = 16; ll_i = 3;
    send_block(64, 1, 0, 2, 0);
    send_block(3, 0, 1, 2, 0);
    drain();

    // offset wraps modulo 2^64
    kk_i = 1; ll_i = 64'hFFFF_FFFF_FFFF_FFFD;
    send_block(61, 0, 1, 2, 1);
    drain();

    // backpressure with an overrun byte
    kk_i = 0; ll_i = 64; core_ready_i = 0;
    send_block(64, 1, 1, 2, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin data_v_i = 1; data_i = 8'h5A; data_idx_i = 6'd7; end
      step();
      data_v_i = 0;
    end
    chk("overrun_err", 512'(err_o), 512'(1));
    drain();

    // reset mid-fill, then refill
    do_reset();
    send_block(31, 1, 0, 2, 0);
    nreset = 0; step(); nreset = 1;
    chk("reset_blk_zero", blk_o, 512'(0));
    send_block(64, 1, 0, 2, 0);
    core_ready_i = 0; step();
    chk("refill_t", 512'(t_o), 512'(64));
    drain();

    // reset while full
    core_ready_i = 0;
    send_block(64, 1, 1, 2, 0);
    step();
    do_reset();
    core_ready_i = 1;

    // randomized messages with random core backpressure
    rand_cr = 1;
    for (int m = 0; m < 25; m++) begin
      rand_msg();
      if ($urandom_range(0, 7) == 0) do_reset();
    end
    drain();
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
